// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
// ============================================================================
// vga_timing_gen
// ----------------------------------------------------------------------------
// Raster timing generator for 640x480 @ 60 Hz VGA (default geometry).
// It divides the system clock down to a one-cycle pixel enable. It then runs
// the horizontal and vertical counters (DrawX/DrawY). Sync and blanking are
// registered from the next counter values, so they line up with the counters
// in the same cycle. frame_start/frame_cnt mark each wrap to (0,0).
//
// Parameters
//   CLK_DIV                              system clocks per pixel (>= 1)
//   H_VISIBLE, H_FRONT, H_SYNC, H_BACK   horizontal timing in pixels
//   V_VISIBLE, V_FRONT, V_SYNC, V_BACK   vertical timing in lines
//   The sum of the H_* values and the sum of the V_* values must each be
//   <= 1024.
//
// Ports
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset
//   pix_tick     out  one-clk pixel enable (combinational from the divider)
//   DrawX        out  horizontal counter, 0..H_TOTAL-1
//   DrawY        out  vertical counter, 0..V_TOTAL-1
//   hs           out  horizontal sync, active low
//   vs           out  vertical sync, active low
//   display_en   out  high while the pixel is inside the visible area
//   frame_start  out  one-clk pulse when the counters register (0,0)
//   frame_cnt    out  frame counter, wraps 255 -> 0
//
// Build option
//   VGA_ROM_DELAY_EN  When defined, hs/vs/display_en pass through one extra
//                     stage that is enabled by pix_tick. They then lag
//                     DrawX/DrawY by one pixel. This matches the one-cycle
//                     synchronous font ROM read in the renderers.
// ============================================================================
module vga_timing_gen #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic       pix_tick,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       display_en,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // The divider needs at least one bit, even when CLK_DIV is 1.
    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    // Region bounds are 11 bits wide, so an upper bound of 1024 cannot alias to 0.
    localparam logic [10:0] H_VIS_END = 11'(H_VISIBLE);
    localparam logic [10:0] HS_BEGIN  = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END    = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_VIS_END = 11'(V_VISIBLE);
    localparam logic [10:0] VS_BEGIN  = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END    = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             de_q, de_d;
    logic             fs_q, fs_d;
    logic [7:0]       fcnt_q, fcnt_d;

    // ------------------------------------------------------------------
    // Clock divider
    // ------------------------------------------------------------------
    assign pix_tick = (div_q == DIV_LAST);

    always_comb begin
        div_d = div_q + 1'b1;
        if (pix_tick) begin
            div_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (pix_tick) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                if (y_q == V_LAST) begin
                    y_d = '0;
                end else begin
                    y_d = y_q + 10'd1;
                end
            end else begin
                x_d = x_q + 10'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sync, blanking and frame marker, decoded from the next counter value
    // ------------------------------------------------------------------
    always_comb begin
        hs_d   = hs_q;
        vs_d   = vs_q;
        de_d   = de_q;
        fs_d   = 1'b0;
        fcnt_d = fcnt_q;
        if (pix_tick) begin
            hs_d = !(({1'b0, x_d} >= HS_BEGIN) && ({1'b0, x_d} < HS_END));
            vs_d = !(({1'b0, y_d} >= VS_BEGIN) && ({1'b0, y_d} < VS_END));
            de_d = ({1'b0, x_d} < H_VIS_END) && ({1'b0, y_d} < V_VIS_END);
            // The X and Y wraps on one tick count as a single frame event.
            if ((x_d == 10'd0) && (y_d == 10'd0)) begin
                fs_d   = 1'b1;
                fcnt_d = fcnt_q + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // Reset parks the counters on the last back-porch pixel. The first tick
    // then lands on (0,0) and emits a frame_start.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q  <= '0;
            x_q    <= H_LAST;
            y_q    <= V_LAST;
            hs_q   <= 1'b1;
            vs_q   <= 1'b1;
            de_q   <= 1'b0;
            fs_q   <= 1'b0;
            fcnt_q <= 8'd0;
        end else begin
            div_q  <= div_d;
            x_q    <= x_d;
            y_q    <= y_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            de_q   <= de_d;
            fs_q   <= fs_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign DrawX       = x_q;
    assign DrawY       = y_q;
    assign frame_start = fs_q;
    assign frame_cnt   = fcnt_q;

`ifdef VGA_ROM_DELAY_EN
    // ------------------------------------------------------------------
    // One-pixel delay on sync/blanking, to cover the renderer ROM read
    // ------------------------------------------------------------------
    logic hs_dly_q, hs_dly_d;
    logic vs_dly_q, vs_dly_d;
    logic de_dly_q, de_dly_d;

    always_comb begin
        hs_dly_d = hs_dly_q;
        vs_dly_d = vs_dly_q;
        de_dly_d = de_dly_q;
        if (pix_tick) begin
            hs_dly_d = hs_q;
            vs_dly_d = vs_q;
            de_dly_d = de_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_dly_q <= 1'b1;
            vs_dly_q <= 1'b1;
            de_dly_q <= 1'b0;
        end else begin
            hs_dly_q <= hs_dly_d;
            vs_dly_q <= vs_dly_d;
            de_dly_q <= de_dly_d;
        end
    end

    assign hs         = hs_dly_q;
    assign vs         = vs_dly_q;
    assign display_en = de_dly_q;
`else
    assign hs         = hs_q;
    assign vs         = vs_q;
    assign display_en = de_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
// Bench for vga_timing_gen. It runs three instances: the default 640x480
// geometry, a small geometry with CLK_DIV=2, and a tiny geometry with
// CLK_DIV=1. A raster model compares every output of every instance on
// each falling clock edge. The model derives the expected values from the
// number of clock edges seen since reset release.
module tb_vga_timing_gen;
    localparam int NI = 3;

    typedef struct packed {
        logic       tick;
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       de;
        logic       fs;
        logic [7:0] fc;
    } exp_t;

    logic          clk = 1'b0;
    logic [NI-1:0] rst_n;
    logic          tick_w [NI];
    logic [9:0]    x_w    [NI];
    logic [9:0]    y_w    [NI];
    logic          hs_w   [NI];
    logic          vs_w   [NI];
    logic          de_w   [NI];
    logic          fs_w   [NI];
    logic [7:0]    fc_w   [NI];

    int cd  [NI] = '{2, 2, 1};
    int hv  [NI] = '{640, 20, 4};
    int hf  [NI] = '{16, 3, 1};
    int hsy [NI] = '{96, 5, 2};
    int hb  [NI] = '{48, 4, 1};
    int vv  [NI] = '{480, 12, 3};
    int vf  [NI] = '{10, 2, 1};
    int vsy [NI] = '{2, 2, 1};
    int vb  [NI] = '{33, 3, 1};

    int ncyc [NI];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_timing_gen u0 (
        .clk(clk), .reset_n(rst_n[0]), .pix_tick(tick_w[0]),
        .DrawX(x_w[0]), .DrawY(y_w[0]), .hs(hs_w[0]), .vs(vs_w[0]),
        .display_en(de_w[0]), .frame_start(fs_w[0]), .frame_cnt(fc_w[0])
    );

    vga_timing_gen #(
        .CLK_DIV(2), .H_VISIBLE(20), .H_FRONT(3), .H_SYNC(5), .H_BACK(4),
        .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
    ) u1 (
        .clk(clk), .reset_n(rst_n[1]), .pix_tick(tick_w[1]),
        .DrawX(x_w[1]), .DrawY(y_w[1]), .hs(hs_w[1]), .vs(vs_w[1]),
        .display_en(de_w[1]), .frame_start(fs_w[1]), .frame_cnt(fc_w[1])
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
    ) u2 (
        .clk(clk), .reset_n(rst_n[2]), .pix_tick(tick_w[2]),
        .DrawX(x_w[2]), .DrawY(y_w[2]), .hs(hs_w[2]), .vs(vs_w[2]),
        .display_en(de_w[2]), .frame_start(fs_w[2]), .frame_cnt(fc_w[2])
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int htot(input int i);
        return hv[i] + hf[i] + hsy[i] + hb[i];
    endfunction

    function automatic int vtot(input int i);
        return vv[i] + vf[i] + vsy[i] + vb[i];
    endfunction

    // Raster position after t pixel ticks. Tick 0 is the last back-porch
    // pixel, and every tick advances the linear pixel index by one.
    function automatic exp_t model(input int i, input int n);
        exp_t e;
        int   tot, t, p, q, qx, qy;
        tot = htot(i) * vtot(i);
        t   = n / cd[i];
        p   = (tot - 1 + t) % tot;
`ifdef VGA_ROM_DELAY_EN
        q   = (tot - 1 + ((t > 0) ? t - 1 : 0)) % tot;
`else
        q   = p;
`endif
        qx     = q % htot(i);
        qy     = q / htot(i);
        e.tick = ((n % cd[i]) == (cd[i] - 1));
        e.x    = 10'(p % htot(i));
        e.y    = 10'(p / htot(i));
        e.hs   = !((qx >= hv[i] + hf[i]) && (qx < hv[i] + hf[i] + hsy[i]));
        e.vs   = !((qy >= vv[i] + vf[i]) && (qy < vv[i] + vf[i] + vsy[i]));
        e.de   = (qx < hv[i]) && (qy < vv[i]);
        e.fs   = (n > 0) && ((n % cd[i]) == 0) && (p == 0);
        e.fc   = 8'(((t + tot - 1) / tot) % 256);
        return e;
    endfunction

    task automatic check_inst(input int i);
        exp_t e;
        e = model(i, rst_n[i] ? ncyc[i] : 0);
        chk($sformatf("u%0d.pix_tick", i),    int'(tick_w[i]), int'(e.tick));
        chk($sformatf("u%0d.DrawX", i),       int'(x_w[i]),    int'(e.x));
        chk($sformatf("u%0d.DrawY", i),       int'(y_w[i]),    int'(e.y));
        chk($sformatf("u%0d.hs", i),          int'(hs_w[i]),   int'(e.hs));
        chk($sformatf("u%0d.vs", i),          int'(vs_w[i]),   int'(e.vs));
        chk($sformatf("u%0d.display_en", i),  int'(de_w[i]),   int'(e.de));
        chk($sformatf("u%0d.frame_start", i), int'(fs_w[i]),   int'(e.fs));
        chk($sformatf("u%0d.frame_cnt", i),   int'(fc_w[i]),   int'(e.fc));
    endtask

    // One clock: count edges out of reset, then compare all instances.
    task automatic step();
        @(posedge clk);
        for (int i = 0; i < NI; i++) begin
            ncyc[i] = rst_n[i] ? ncyc[i] + 1 : 0;
        end
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check_inst(i);
        end
    endtask

    initial begin
        int cnt;
        int lowt;
        int k;
        int gap;
        int hold;

        rst_n = '0;
        for (int i = 0; i < NI; i++) ncyc[i] = 0;
        repeat (3) step();
        #2 rst_n = '1;

        // Default geometry: hs falls at X=656 and stays low for 96 ticks.
        cnt = 0;
        while (hs_w[0] !== 1'b0 && cnt < 4000) begin
            step();
            cnt++;
        end
        chk("u0.hs_fall_in_time", int'(cnt < 4000), 1);
        chk("u0.hs_fall_x", int'(x_w[0]), 656);
        lowt = 0;
        cnt  = 0;
        while (hs_w[0] === 1'b0 && cnt < 1000) begin
            if (tick_w[0]) lowt++;
            step();
            cnt++;
        end
        chk("u0.hs_low_ticks", lowt, 96);
        cnt = 0;
        while (x_w[0] !== 10'd0 && cnt < 1000) begin
            step();
            cnt++;
        end
        chk("u0.line_wrap_y", int'(y_w[0]), 1);

        // Small CLK_DIV=2 geometry: the spacing between frame_start pulses.
        cnt = 0;
        while (fs_w[1] !== 1'b1 && cnt < 3000) begin
            step();
            cnt++;
        end
        chk("u1.first_fs_in_time", int'(cnt < 3000), 1);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (fs_w[1] !== 1'b1 && cnt < 3000);
        chk("u1.frame_period", cnt, 2 * 32 * 19);

        // Tiny CLK_DIV=1 geometry: the 256th frame_start wraps frame_cnt to 0.
        cnt = 0;
        while (!(fs_w[2] === 1'b1 && fc_w[2] === 8'd0) && cnt < 14000) begin
            step();
            cnt++;
        end
        chk("u2.fcnt_wrap_edge", ncyc[2], 1 + 255 * 48);

        // Random mid-frame resets: async clear, then a clean restart.
        for (int r = 0; r < 6; r++) begin
            k    = int'($urandom_range(0, NI - 1));
            gap  = int'($urandom_range(5, 2000));
            hold = int'($urandom_range(1, 4));
            repeat (gap) step();
            #2 rst_n[k] = 1'b0;
            #1 check_inst(k);
            repeat (hold) step();
            #2 rst_n[k] = 1'b1;
        end
        repeat (300) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
